// File: rtl/cache_fm_ctrl_if.sv
// Cache <-> far-memory controller request/response channel.
// The cache side is master; the controller is slave.
interface cache_fm_ctrl_if #(
  parameter int unsigned ADRS_WIDTH  = 20,
  parameter int unsigned CL_WIDTH    = 128,
  parameter int unsigned TQ_ID_WIDTH = 3
);
  logic                   req_valid;
  logic [1:0]             req_opcode;
  logic [ADRS_WIDTH-1:0]  req_adrs;
  logic [TQ_ID_WIDTH-1:0] req_tq_id;
  logic [CL_WIDTH-1:0]    req_data;
  logic                   rsp_valid;
  logic [TQ_ID_WIDTH-1:0] rsp_tq_id;
  logic [CL_WIDTH-1:0]    rsp_data;

  modport master (
    output req_valid, req_opcode, req_adrs, req_tq_id, req_data,
    input  rsp_valid, rsp_tq_id, rsp_data
  );

  modport slave (
    input  req_valid, req_opcode, req_adrs, req_tq_id, req_data,
    output rsp_valid, rsp_tq_id, rsp_data
  );
endinterface

// File: rtl/cache_fm_ctrl.sv
// Far-memory controller: in-order request FIFO feeding a single-port array,
// write-occupancy FSM and a fixed-latency fill response pipe.
module cache_fm_ctrl #(
  parameter int unsigned ADRS_WIDTH  = 20,
  parameter int unsigned CL_WIDTH    = 128,
  parameter int unsigned TQ_ID_WIDTH = 3,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned RD_LATENCY  = 9,
  parameter int unsigned WR_CYCLES   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  cache_fm_ctrl_if.slave                fm,
  output logic                          mem_wr_en,
  output logic [ADRS_WIDTH-1:0]         mem_adrs,
  output logic [CL_WIDTH-1:0]           mem_wr_data,
  input  logic [CL_WIDTH-1:0]           mem_rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          idle,
  output logic                          overflow_err
);

  localparam logic [1:0]  FILL_REQ_OP    = 2'b01;
  localparam logic [1:0]  DIRTY_EVICT_OP = 2'b10;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned PIPE_D = RD_LATENCY - 1;
  localparam int unsigned WC_W   = $clog2(WR_CYCLES + 1);

  typedef struct packed {
    logic [1:0]             opcode;
    logic [ADRS_WIDTH-1:0]  adrs;
    logic [TQ_ID_WIDTH-1:0] tq_id;
    logic [CL_WIDTH-1:0]    data;
  } entry_t;

  typedef enum logic {IDLE, WR_BUSY} state_t;

  state_t                 state;
  logic [WC_W-1:0]        wr_cnt;
  entry_t                 fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [ADRS_WIDTH-1:0]  adrs_q;
  logic [CL_WIDTH-1:0]    wr_data_q;

  logic                   s0_valid;
  logic [TQ_ID_WIDTH-1:0] s0_tq;
  logic [PIPE_D-1:0]      pipe_v;
  logic [TQ_ID_WIDTH-1:0] pipe_tq   [PIPE_D];
  logic [CL_WIDTH-1:0]    pipe_data [PIPE_D];

  entry_t head;
  logic   req_ok, full, pop, push, issue_fill, issue_wr;

  // Issue decode: the head is popped and driven onto the array in the same cycle.
  assign head        = fifo_mem[rd_ptr];
  assign req_ok      = fm.req_valid &&
                       (fm.req_opcode == FILL_REQ_OP || fm.req_opcode == DIRTY_EVICT_OP);
  assign full        = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign pop         = (state == IDLE) && (fifo_count != '0);
  assign push        = req_ok && (!full || pop);
  assign issue_fill  = pop && (head.opcode == FILL_REQ_OP);
  assign issue_wr    = pop && (head.opcode != FILL_REQ_OP);

  assign mem_wr_en   = issue_wr;
  assign mem_adrs    = pop ? head.adrs : adrs_q;
  assign mem_wr_data = issue_wr ? head.data : wr_data_q;

  assign idle = (fifo_count == '0) && (state == IDLE) && !s0_valid &&
                (pipe_v == '0) && !fm.rsp_valid;

  // FIFO storage; validity is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{opcode: fm.req_opcode, adrs: fm.req_adrs,
                            tq_id: fm.req_tq_id, data: fm.req_data};
    end
  end

  // FIFO control, array-port hold registers and write-occupancy FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      overflow_err <= 1'b0;
      adrs_q       <= '0;
      wr_data_q    <= '0;
      state        <= IDLE;
      wr_cnt       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      if (req_ok && full && !pop) overflow_err <= 1'b1;
      if (pop)      adrs_q    <= head.adrs;
      if (issue_wr) wr_data_q <= head.data;
      case (state)
        IDLE: begin
          if (issue_wr && WR_CYCLES > 1) begin
            state  <= WR_BUSY;
            wr_cnt <= WC_W'(WR_CYCLES - 1);
          end
        end
        WR_BUSY: begin
          if (wr_cnt <= WC_W'(1)) state <= IDLE;
          else                    wr_cnt <= wr_cnt - WC_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data side of the latency pipe carries no reset; only valid bits matter.
  always_ff @(posedge clk) begin
    pipe_data[0] <= mem_rd_data;
    for (int i = 1; i < int'(PIPE_D); i++) pipe_data[i] <= pipe_data[i-1];
  end

  // Latency pipe control and registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid     <= 1'b0;
      s0_tq        <= '0;
      pipe_v       <= '0;
      for (int i = 0; i < int'(PIPE_D); i++) pipe_tq[i] <= '0;
      fm.rsp_valid <= 1'b0;
      fm.rsp_tq_id <= '0;
      fm.rsp_data  <= '0;
    end else begin
      s0_valid <= issue_fill;
      if (issue_fill) s0_tq <= head.tq_id;
      pipe_v[0]  <= s0_valid;
      pipe_tq[0] <= s0_tq;
      for (int i = 1; i < int'(PIPE_D); i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_tq[i] <= pipe_tq[i-1];
      end
      fm.rsp_valid <= pipe_v[PIPE_D-1];
      if (pipe_v[PIPE_D-1]) begin
        fm.rsp_tq_id <= pipe_tq[PIPE_D-1];
        fm.rsp_data  <= pipe_data[PIPE_D-1];
      end
    end
  end

endmodule

// File: tb/tb_cache_fm_ctrl.sv
// Scoreboard bench for cache_fm_ctrl: directed requests push expected fills,
// a negedge monitor pops and checks every response.
module tb_cache_fm_ctrl;
  localparam logic [1:0] FILL  = 2'b01;
  localparam logic [1:0] EVICT = 2'b10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_wr_en;
  logic [19:0]  mem_adrs;
  logic [127:0] mem_wr_data;
  logic [127:0] mem_rd_data = '0;
  logic [3:0]   fifo_count;
  logic         idle;
  logic         overflow_err;

  cache_fm_ctrl_if fm ();

  cache_fm_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .fm           (fm),
    .mem_wr_en    (mem_wr_en),
    .mem_adrs     (mem_adrs),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_data  (mem_rd_data),
    .fifo_count   (fifo_count),
    .idle         (idle),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Far-memory array model: registered read of the pre-edge contents.
  logic [127:0] arr [logic [19:0]];

  function automatic logic [127:0] mem_model(input logic [19:0] a);
    if (arr.exists(a)) return arr[a];
    return {16'hF00D, 92'd0, a};
  endfunction

  always @(posedge clk) begin
    mem_rd_data <= mem_model(mem_adrs);
    if (mem_wr_en) arr[mem_adrs] = mem_wr_data;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [2:0]   tq;
    logic [127:0] data;
    int           at;   // expected response cycle, -1 = not checked
  } exp_t;
  exp_t sbq[$];

  int           max_cnt  = 0;
  int           wr_pulses = 0;
  int           wr_cyc   = -1;
  logic [19:0]  wr_adrs  = '0;
  logic [127:0] wr_data  = '0;

  // Monitor: response checking plus array-port and occupancy tracking.
  always @(negedge clk) begin
    if (!rst) begin
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (mem_wr_en) begin
        wr_pulses++;
        wr_cyc  = cyc;
        wr_adrs = mem_adrs;
        wr_data = mem_wr_data;
      end
      if (fm.rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rsp_valid", 128'(fm.rsp_tq_id), 128'hFFFF);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("rsp_tq_id", 128'(fm.rsp_tq_id), 128'(e.tq));
          chk("rsp_data", fm.rsp_data, e.data);
          if (e.at >= 0) chk("rsp_cycle", 128'(cyc), 128'(e.at));
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [19:0] a,
                      input logic [2:0] t, input logic [127:0] d);
    fm.req_valid  = 1'b1;
    fm.req_opcode = op;
    fm.req_adrs   = a;
    fm.req_tq_id  = t;
    fm.req_data   = d;
    @(posedge clk); #1;
  endtask

  task automatic quiet(input int n);
    fm.req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expect_fill(input logic [2:0] t, input logic [127:0] d, input int at);
    exp_t e;
    e.tq = t; e.data = d; e.at = at;
    sbq.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 80) begin @(posedge clk); #1; n++; end
    if (sbq.size() != 0) chk({name, "_drain_timeout"}, 128'(sbq.size()), 128'd0);
    quiet(2);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_wr_en"},    128'(mem_wr_en), 128'd0);
    chk({tag, "_mem_adrs"},     128'(mem_adrs), 128'd0);
    chk({tag, "_mem_wr_data"},  mem_wr_data, 128'd0);
    chk({tag, "_rsp_valid"},    128'(fm.rsp_valid), 128'd0);
    chk({tag, "_rsp_tq_id"},    128'(fm.rsp_tq_id), 128'd0);
    chk({tag, "_rsp_data"},     fm.rsp_data, 128'd0);
    chk({tag, "_fifo_count"},   128'(fifo_count), 128'd0);
    chk({tag, "_idle"},         128'(idle), 128'd1);
    chk({tag, "_overflow_err"}, 128'(overflow_err), 128'd0);
  endtask

  initial begin
    int c;
    fm.req_valid  = 1'b0;
    fm.req_opcode = 2'b00;
    fm.req_adrs   = '0;
    fm.req_tq_id  = '0;
    fm.req_data   = '0;
    arr[20'h00012] = {16{8'hA5}};
    #2;
    chk_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single fill: request at cycle 100, response exactly at cycle 111.
    while (cyc < 100) begin @(posedge clk); #1; end
    expect_fill(3'd2, {16{8'hA5}}, 111);
    send(FILL, 20'h00012, 3'd2, '0);
    quiet(0);
    while (cyc < 111) begin @(posedge clk); #1; end
    chk("single_idle_at_111", 128'(idle), 128'd0);
    @(posedge clk); #1;
    chk("single_idle_at_112", 128'(idle), 128'd1);
    chk("single_rsp_valid_low", 128'(fm.rsp_valid), 128'd0);
    chk("single_rsp_tq_hold", 128'(fm.rsp_tq_id), 128'd2);
    drain("single");

    // Evict then fill same address: write issues first, fill 4 cycles later.
    wr_pulses = 0;
    c = cyc;
    send(EVICT, 20'h00040, 3'd0, 128'h1234);
    expect_fill(3'd5, 128'h1234, c + 15);
    send(FILL, 20'h00040, 3'd5, '0);
    quiet(20);
    drain("evict_fill");
    chk("evict_wr_pulses", 128'(wr_pulses), 128'd1);
    chk("evict_wr_cycle", 128'(wr_cyc), 128'(c + 1));
    chk("evict_wr_adrs", 128'(wr_adrs), 128'h40);
    chk("evict_wr_data", wr_data, 128'h1234);

    // Eight back-to-back fills stream out in order on consecutive cycles.
    max_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      expect_fill(3'(k), mem_model(20'h00100 + 20'(k)), cyc + 11);
      send(FILL, 20'h00100 + 20'(k), 3'(k), '0);
    end
    quiet(1);
    drain("b2b");
    chk("b2b_max_fifo_count", 128'(max_cnt), 128'd1);

    // Overflow: 4 evicts + 8 fills; the 12th request finds the FIFO full.
    max_cnt   = 0;
    wr_pulses = 0;
    c = cyc;
    for (int k = 0; k < 4; k++)
      send(EVICT, 20'h00200 + 20'(k), 3'd0, 128'hE0 + 128'(k));
    for (int k = 0; k < 8; k++) begin
      if (k < 4) expect_fill(3'(k), 128'hE0 + 128'(k), c + 27 + k);
      else if (k < 7) expect_fill(3'(k), mem_model(20'h00300 + 20'(k - 4)), c + 27 + k);
      send(FILL, (k < 4) ? 20'h00200 + 20'(k) : 20'h00300 + 20'(k - 4), 3'(k), '0);
    end
    chk("ovf_count_full", 128'(fifo_count), 128'd8);
    chk("ovf_err_set", 128'(overflow_err), 128'd1);
    quiet(1);
    drain("ovf");
    quiet(10);
    chk("ovf_max_fifo_count", 128'(max_cnt), 128'd8);
    chk("ovf_err_sticky", 128'(overflow_err), 128'd1);
    chk("ovf_wr_pulses", 128'(wr_pulses), 128'd4);

    // Unsupported opcodes are ignored.
    send(2'b00, 20'h00500, 3'd1, '0);
    chk("badop0_fifo_count", 128'(fifo_count), 128'd0);
    send(2'b11, 20'h00501, 3'd2, '0);
    chk("badop3_fifo_count", 128'(fifo_count), 128'd0);
    quiet(15);
    chk("badop_idle", 128'(idle), 128'd1);

    // Reset with fills in flight discards them.
    for (int k = 0; k < 3; k++) send(FILL, 20'h00400 + 20'(k), 3'(k + 1), '0);
    quiet(4);
    chk("pre_rst_idle", 128'(idle), 128'd0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    sbq.delete();
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    quiet(20);
    chk("post_rst_idle", 128'(idle), 128'd1);
    expect_fill(3'd6, mem_model(20'h00600), cyc + 11);
    send(FILL, 20'h00600, 3'd6, '0);
    quiet(1);
    drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
